// File: rtl/mxint8_add_ctrl_pkg.sv
// Shared sizing defaults, the E8M0 NaN scale code and the controller state
// encoding used by the MX int8 add sequencer.
package mxint8_add_ctrl_pkg;

  localparam int BLOCK_SIZE_DEF  = 32;
  localparam int ELEM_WIDTH_DEF  = 8;
  localparam int SCALE_WIDTH_DEF = 8;

  localparam logic [SCALE_WIDTH_DEF-1:0] SCALE_NAN = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/mxint8_add.sv
// Combinational MX int8 block adder: aligns the smaller-scale block to the
// larger shared scale by arithmetic right shift, then adds with saturation.
module mxint8_add #(
  parameter int BLOCK_SIZE  = 32,
  parameter int ELEM_WIDTH  = 8,
  parameter int SCALE_WIDTH = 8
) (
  input  logic [SCALE_WIDTH-1:0] i_scale_a,
  input  logic [SCALE_WIDTH-1:0] i_scale_b,
  input  logic [ELEM_WIDTH-1:0]  i_elements_a [BLOCK_SIZE],
  input  logic [ELEM_WIDTH-1:0]  i_elements_b [BLOCK_SIZE],
  output logic [SCALE_WIDTH-1:0] o_scale,
  output logic [ELEM_WIDTH-1:0]  o_elements [BLOCK_SIZE],
  output logic                   o_overflow
);

  localparam logic signed [ELEM_WIDTH:0] SumMax = {2'b00, {(ELEM_WIDTH-1){1'b1}}};
  localparam logic signed [ELEM_WIDTH:0] SumMin = {2'b11, {(ELEM_WIDTH-1){1'b0}}};
  localparam logic [ELEM_WIDTH-1:0] ElemMax = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
  localparam logic [ELEM_WIDTH-1:0] ElemMin = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

  logic                         a_smaller;
  logic [SCALE_WIDTH-1:0]       shift;
  logic signed [ELEM_WIDTH-1:0] ea;
  logic signed [ELEM_WIDTH-1:0] eb;
  logic signed [ELEM_WIDTH:0]   sum;

  // Shifts of a full element width or more collapse to the sign fill.
  always_comb begin
    a_smaller  = i_scale_a < i_scale_b;
    o_scale    = a_smaller ? i_scale_b : i_scale_a;
    shift      = a_smaller ? (i_scale_b - i_scale_a) : (i_scale_a - i_scale_b);
    o_overflow = 1'b0;
    ea         = '0;
    eb         = '0;
    sum        = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      ea = $signed(i_elements_a[i]);
      eb = $signed(i_elements_b[i]);
      if (a_smaller) begin
        ea = ea >>> shift;
      end else begin
        eb = eb >>> shift;
      end
      sum = {ea[ELEM_WIDTH-1], ea} + {eb[ELEM_WIDTH-1], eb};
      if (sum > SumMax) begin
        o_elements[i] = ElemMax;
        o_overflow    = 1'b1;
      end else if (sum < SumMin) begin
        o_elements[i] = ElemMin;
        o_overflow    = 1'b1;
      end else begin
        o_elements[i] = sum[ELEM_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mxint8_rr_arb2.sv
// Two-input round-robin arbiter: a lone request always wins, and a tie goes
// to whichever requester did not win last time.
module mxint8_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  always_comb begin
    o_grant_id = 1'b0;
    case (i_valid)
      2'b01:   o_grant_id = 1'b0;
      2'b10:   o_grant_id = 1'b1;
      2'b11:   o_grant_id = ~i_last_grant;
      default: o_grant_id = 1'b0;
    endcase
    if (i_valid == 2'b00) begin
      o_grant = 2'b00;
    end else begin
      o_grant = o_grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mxint8_add_ctrl.sv
// Shares one mxint8_add datapath between two requesters: round-robin accept,
// one execute cycle, then a registered result held until the consumer takes it.
module mxint8_add_ctrl
  import mxint8_add_ctrl_pkg::*;
#(
  parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF,
  parameter int ELEM_WIDTH  = ELEM_WIDTH_DEF,
  parameter int SCALE_WIDTH = SCALE_WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [SCALE_WIDTH-1:0] i_req0_scale_a,
  input  logic [SCALE_WIDTH-1:0] i_req0_scale_b,
  input  logic [ELEM_WIDTH-1:0]  i_req0_elements_a [BLOCK_SIZE],
  input  logic [ELEM_WIDTH-1:0]  i_req0_elements_b [BLOCK_SIZE],
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic [SCALE_WIDTH-1:0] i_req1_scale_a,
  input  logic [SCALE_WIDTH-1:0] i_req1_scale_b,
  input  logic [ELEM_WIDTH-1:0]  i_req1_elements_a [BLOCK_SIZE],
  input  logic [ELEM_WIDTH-1:0]  i_req1_elements_b [BLOCK_SIZE],
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic                   o_res_id,
  output logic [SCALE_WIDTH-1:0] o_res_scale,
  output logic [ELEM_WIDTH-1:0]  o_res_elements [BLOCK_SIZE],
  output logic                   o_res_overflow,
  output logic                   o_busy
);

  ctrl_state_e state_q, state_d;
  logic        last_grant_q;
  logic [1:0]  grant;
  logic        grant_id;
  logic        accept_window;
  logic        accept;

  logic [SCALE_WIDTH-1:0] sel_scale_a, sel_scale_b;
  logic [ELEM_WIDTH-1:0]  sel_elem_a [BLOCK_SIZE];
  logic [ELEM_WIDTH-1:0]  sel_elem_b [BLOCK_SIZE];

  logic                   op_id_q;
  logic [SCALE_WIDTH-1:0] op_scale_a_q, op_scale_b_q;
  logic [ELEM_WIDTH-1:0]  op_elem_a_q [BLOCK_SIZE];
  logic [ELEM_WIDTH-1:0]  op_elem_b_q [BLOCK_SIZE];

  logic [SCALE_WIDTH-1:0] add_scale;
  logic [ELEM_WIDTH-1:0]  add_elem [BLOCK_SIZE];
  logic                   add_ovf;
  logic                   scale_nan;

  logic                   res_id_q;
  logic [SCALE_WIDTH-1:0] res_scale_q;
  logic [ELEM_WIDTH-1:0]  res_elem_q [BLOCK_SIZE];
  logic                   res_ovf_q;

  mxint8_rr_arb2 u_arb (
    .i_valid      ({i_req1_valid, i_req0_valid}),
    .i_last_grant (last_grant_q),
    .o_grant      (grant),
    .o_grant_id   (grant_id)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant_id;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (i_res_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accepting in DONE alongside the result handshake keeps one result per two cycles.
  always_comb begin
    accept_window = (state_q == IDLE) || ((state_q == DONE) && i_res_ready);
    o_req0_ready  = accept_window & grant[0];
    o_req1_ready  = accept_window & grant[1];
    accept        = (o_req0_ready & i_req0_valid) | (o_req1_ready & i_req1_valid);
    o_res_valid   = (state_q == DONE);
    o_busy        = (state_q != IDLE);
  end

  always_comb begin
    sel_scale_a = grant_id ? i_req1_scale_a : i_req0_scale_a;
    sel_scale_b = grant_id ? i_req1_scale_b : i_req0_scale_b;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sel_elem_a[i] = grant_id ? i_req1_elements_a[i] : i_req0_elements_a[i];
      sel_elem_b[i] = grant_id ? i_req1_elements_b[i] : i_req0_elements_b[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_id_q      <= 1'b0;
      op_scale_a_q <= '0;
      op_scale_b_q <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        op_elem_a_q[i] <= '0;
        op_elem_b_q[i] <= '0;
      end
    end else if (accept) begin
      op_id_q      <= grant_id;
      op_scale_a_q <= sel_scale_a;
      op_scale_b_q <= sel_scale_b;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        op_elem_a_q[i] <= sel_elem_a[i];
        op_elem_b_q[i] <= sel_elem_b[i];
      end
    end
  end

  mxint8_add #(
    .BLOCK_SIZE  (BLOCK_SIZE),
    .ELEM_WIDTH  (ELEM_WIDTH),
    .SCALE_WIDTH (SCALE_WIDTH)
  ) u_add (
    .i_scale_a    (op_scale_a_q),
    .i_scale_b    (op_scale_b_q),
    .i_elements_a (op_elem_a_q),
    .i_elements_b (op_elem_b_q),
    .o_scale      (add_scale),
    .o_elements   (add_elem),
    .o_overflow   (add_ovf)
  );

  assign scale_nan = (&op_scale_a_q) | (&op_scale_b_q);

  // A NaN scale on either operand overrides whatever the adder produced.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_id_q    <= 1'b0;
      res_scale_q <= '0;
      res_ovf_q   <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        res_elem_q[i] <= '0;
      end
    end else if (state_q == EXEC) begin
      res_id_q    <= op_id_q;
      res_scale_q <= scale_nan ? '1 : add_scale;
      res_ovf_q   <= scale_nan ? 1'b0 : add_ovf;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        res_elem_q[i] <= scale_nan ? '0 : add_elem[i];
      end
    end
  end

  assign o_res_id       = res_id_q;
  assign o_res_scale    = res_scale_q;
  assign o_res_overflow = res_ovf_q;
  assign o_res_elements = res_elem_q;

endmodule
